// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one RV64 alu between NUM_REQ requesters.
// It drives the alu from the granted requester and keeps the result in a single registered response slot.
module alu_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ*CONTROL_WIDTH-1:0]  i_req_control,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_src_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_src_2,
  output logic [CONTROL_WIDTH-1:0]          o_alu_control,
  output logic [DATA_WIDTH-1:0]             o_alu_src_1,
  output logic [DATA_WIDTH-1:0]             o_alu_src_2,
  input  logic [DATA_WIDTH-1:0]             i_alu_result,
  input  logic [5:0]                        i_alu_flags,
  output logic [NUM_REQ-1:0]                o_rsp_valid,
  input  logic [NUM_REQ-1:0]                i_rsp_ready,
  output logic [DATA_WIDTH-1:0]             o_rsp_result,
  output logic [5:0]                        o_rsp_flags,
  output logic                              o_rsp_illegal
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CONTROL_WIDTH-1:0] MAX_LEGAL = CONTROL_WIDTH'(5'b10010);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] lock_idx;
  logic             locked;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  logic [NUM_REQ-1:0] grant;
  logic             can_accept;
  logic             accept;
  logic             drain;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx, input int off);
    int sum;
    sum = int'(idx) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  function automatic logic is_illegal(input logic [CONTROL_WIDTH-1:0] ctrl);
    return ctrl > MAX_LEGAL;
  endfunction

  // A requester left waiting keeps the grant until it is accepted, so its
  // operands on the alu cannot change underneath it.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[wrap_add(ptr, i)]) begin
        found     = 1'b1;
        grant_idx = wrap_add(ptr, i);
      end
    end
    if (locked && i_req_valid[lock_idx]) begin
      found     = 1'b1;
      grant_idx = lock_idx;
    end
  end

  assign grant      = found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign drain      = (state == HOLD) && i_rsp_ready[owner];
  assign can_accept = (state == IDLE) || drain;
  assign accept     = found && can_accept;

  always_comb begin
    o_alu_control = '0;
    o_alu_src_1   = '0;
    o_alu_src_2   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        o_alu_control = i_req_control[k*CONTROL_WIDTH +: CONTROL_WIDTH];
        o_alu_src_1   = i_req_src_1[k*DATA_WIDTH +: DATA_WIDTH];
        o_alu_src_2   = i_req_src_2[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (drain && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rsp_valid = (state == HOLD) ? (NUM_REQ'(1) << owner) : '0;
    o_req_ready = grant & {NUM_REQ{can_accept}};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ptr      <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      locked   <= found && !can_accept;
      lock_idx <= grant_idx;
      if (accept) begin
        ptr   <= wrap_add(grant_idx, 1);
        owner <= grant_idx;
      end
    end
  end

  // Response slot: loaded only on accept, otherwise holds the last response.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      o_rsp_result  <= '0;
      o_rsp_flags   <= '0;
      o_rsp_illegal <= 1'b0;
    end else if (accept) begin
      o_rsp_result  <= i_alu_result;
      o_rsp_flags   <= i_alu_flags;
      o_rsp_illegal <= is_illegal(o_alu_control);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural alu attached.
module tb_alu_arbiter;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int CW = 5;

  logic             clk;
  logic             arstn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*CW-1:0] req_control;
  logic [NR*DW-1:0] req_src_1;
  logic [NR*DW-1:0] req_src_2;
  logic [CW-1:0]    alu_control;
  logic [DW-1:0]    alu_src_1;
  logic [DW-1:0]    alu_src_2;
  logic [DW-1:0]    alu_result;
  logic [5:0]       alu_flags;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [DW-1:0]    rsp_result;
  logic [5:0]       rsp_flags;
  logic             rsp_illegal;

  int n_cmp;
  int n_bad;

  alu_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) dut (
    .clk(clk), .arstn(arstn),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_control(req_control), .i_req_src_1(req_src_1), .i_req_src_2(req_src_2),
    .o_alu_control(alu_control), .o_alu_src_1(alu_src_1), .o_alu_src_2(alu_src_2),
    .i_alu_result(alu_result), .i_alu_flags(alu_flags),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags), .o_rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in alu: 0 = ADD, 1 = SUB, codes above 5'b10010 give 0; flags carry only zero/negative.
  always_comb begin
    alu_result = '0;
    if (alu_control == 5'd1)       alu_result = alu_src_1 - alu_src_2;
    else if (alu_control > 5'd18)  alu_result = '0;
    else                           alu_result = alu_src_1 + alu_src_2;
    alu_flags = {1'b0, alu_result == '0, alu_result[DW-1], 3'b000};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[k]            = v;
    req_control[k*CW +: CW] = c;
    req_src_1[k*DW +: DW]   = a;
    req_src_2[k*DW +: DW]   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    arstn       = 1'b0;
    req_valid   = '0;
    req_control = '0;
    req_src_1   = '0;
    req_src_2   = '0;
    rsp_ready   = '0;
    tick();
    tick();
    check("rst_rsp_valid",   rsp_valid,   2'b00);
    check("rst_rsp_result",  rsp_result,  64'd0);
    check("rst_rsp_flags",   rsp_flags,   6'd0);
    check("rst_rsp_illegal", rsp_illegal, 1'b0);
    check("rst_req_ready",   req_ready,   2'b00);
    check("rst_alu_ctrl",    alu_control, 5'd0);
    arstn = 1'b1;
    tick();

    // 1: single ADD 3+4 from requester 0
    set_req(0, 1'b1, 5'd0, 64'd3, 64'd4);
    rsp_ready = 2'b11;
    #1;
    check("t1_req_ready", req_ready, 2'b01);
    check("t1_alu_src_1", alu_src_1, 64'd3);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_result",    rsp_result, 64'd7);
    check("t1_flags",     rsp_flags, 6'b000000);
    tick();
    check("t1_drained",   rsp_valid, 2'b00);
    check("t1_held",      rsp_result, 64'd7);

    // 4: requester 1 SUB 5-5 (pointer is 1 here)
    set_req(1, 1'b1, 5'd1, 64'd5, 64'd5);
    #1;
    check("t4_req_ready", req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t4_rsp_valid", rsp_valid, 2'b10);
    check("t4_result",    rsp_result, 64'd0);
    check("t4_flags",     rsp_flags, 6'b010000);
    tick();
    check("t4_drained",   rsp_valid, 2'b00);

    // 2: both requesters always valid, responses always drained
    set_req(0, 1'b1, 5'd0, 64'd10, 64'd1);
    set_req(1, 1'b1, 5'd0, 64'd20, 64'd2);
    #1;
    check("t2_first_grant", req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_rsp_valid_%0d", i), rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t2_result_%0d", i),    rsp_result, (i % 2 == 0) ? 64'd11 : 64'd22);
      check($sformatf("t2_req_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
    tick();
    check("t2_drained", rsp_valid, 2'b00);

    // 3: stall in HOLD, sticky grant, then drain + accept on the same edge
    set_req(0, 1'b1, 5'd0, 64'd7, 64'd8);
    rsp_ready = 2'b00;
    tick();
    set_req(0, 1'b1, 5'd0, 64'd9, 64'd9);
    #1;
    check("t3_stall_ready_a",  req_ready, 2'b00);
    check("t3_stall_valid_a",  rsp_valid, 2'b01);
    check("t3_stall_result_a", rsp_result, 64'd15);
    check("t3_stall_src_a",    alu_src_1, 64'd9);
    tick();
    set_req(1, 1'b1, 5'd0, 64'd1, 64'd1);
    #1;
    check("t3_stall_ready_b",  req_ready, 2'b00);
    check("t3_sticky_src_b",   alu_src_1, 64'd9);
    tick();
    check("t3_stall_result_c", rsp_result, 64'd15);
    check("t3_sticky_src_c",   alu_src_1, 64'd9);
    rsp_ready = 2'b11;
    #1;
    check("t3_release_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t3_new_valid",  rsp_valid, 2'b01);
    check("t3_new_result", rsp_result, 64'd18);
    check("t3_next_ready", req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t3_req1_valid",  rsp_valid, 2'b10);
    check("t3_req1_result", rsp_result, 64'd2);
    tick();

    // 5: illegal control, then a legal op
    set_req(0, 1'b1, 5'b11111, 64'd5, 64'd6);
    #1;
    check("t5_req_ready", req_ready, 2'b01);
    check("t5_alu_ctrl",  alu_control, 5'b11111);
    tick();
    set_req(0, 1'b1, 5'd0, 64'd1, 64'd2);
    #1;
    check("t5_illegal",     rsp_illegal, 1'b1);
    check("t5_ill_result",  rsp_result, 64'd0);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t5_legal",        rsp_illegal, 1'b0);
    check("t5_legal_result", rsp_result, 64'd3);
    tick();

    // 6: asynchronous reset while a response is pending
    set_req(0, 1'b1, 5'd0, 64'd4, 64'd4);
    rsp_ready = 2'b00;
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t6_hold", rsp_valid, 2'b01);
    #1;
    arstn = 1'b0;
    #1;
    check("t6_rst_valid",  rsp_valid, 2'b00);
    check("t6_rst_result", rsp_result, 64'd0);
    tick();
    arstn = 1'b1;
    rsp_ready = 2'b11;
    tick();
    check("t6_no_rsp", rsp_valid, 2'b00);
    set_req(0, 1'b1, 5'd0, 64'd1, 64'd1);
    set_req(1, 1'b1, 5'd0, 64'd2, 64'd2);
    #1;
    check("t6_ptr_zero", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
    set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
    #1;
    check("t6_after_result", rsp_result, 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
